tl_ul_mem_responder: RTL

TL_UL_MEM_RESPONDER -- requirements
Module: tl_ul_mem_responder

---
 rtl/tl_ul_mem_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/tl_ul_mem_responder.sv
// tl_ul_mem_responder: TileLink-UL slave backed by a 64-bit word memory.
// Serves Get, PutFullData and PutPartialData, one request at a time.
// Ports: clock, resetn (sync, active-low); A channel a_valid/a_ready,
//   a_opcode, a_size, a_source, a_address, a_mask, a_data;
//   D channel d_valid/d_ready, d_opcode, d_size, d_source, d_denied, d_data.
// Build option: define TLMEM_BOUNDS_CHECK_EN to deny requests whose first
//   address falls outside the memory window.
module tl_ul_mem_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned RESP_DELAY = 1
) (
    input  logic        clock,
    input  logic        resetn,
    output logic        a_ready,
    input  logic        a_valid,
    input  logic [2:0]  a_opcode,
    input  logic [3:0]  a_size,
    input  logic        a_source,
    input  logic [31:0] a_address,
    input  logic [7:0]  a_mask,
    input  logic [63:0] a_data,
    input  logic        d_ready,
    output logic        d_valid,
    output logic [2:0]  d_opcode,
    output logic [3:0]  d_size,
    output logic        d_source,
    output logic        d_denied,
    output logic [63:0] d_data
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [3:0] DLY_INIT =
        (RESP_DELAY == 0) ? 4'd0 : 4'(RESP_DELAY - 1);

    typedef enum logic [1:0] {IDLE, WDATA, DELAY, RESP} state_e;

    state_e         state_q, state_d;
    logic           src_q, src_d;
    logic [3:0]     size_q, size_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [12:0]    left_q, left_d;
    logic [3:0]     dly_q, dly_d;
    logic           get_q, get_d;
    logic           den_q, den_d;

    logic [63:0]    mem [MEM_WORDS];

    logic           wr_en;
    logic [IW-1:0]  wr_idx;
    logic [7:0]     wr_mask;
    logic [63:0]    wr_data;

    logic           a_hs, d_hs;
    logic [31:0]    a_off;
    logic [IW-1:0]  a_idx;
    logic [12:0]    a_beats;
    logic           op_put, op_get, oob;
    state_e         post_state;
    logic           unused_off;

    function automatic logic [12:0] beats_of(input logic [3:0] sz);
        if (sz <= 4'd3) return 13'd1;
        return 13'd1 << (sz - 4'd3);
    endfunction

    assign a_ready  = (state_q == IDLE) || (state_q == WDATA);
    assign d_valid  = (state_q == RESP);
    assign a_hs     = a_valid && a_ready;
    assign d_hs     = d_valid && d_ready;

    assign a_off    = a_address - ADDR_BASE;
    assign a_idx    = a_off[IW+2:3];
    assign a_beats  = beats_of(a_size);
    assign op_put   = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    assign op_get   = (a_opcode == 3'd4);
    assign unused_off = ^{a_off[31:IW+3], a_off[2:0]};

`ifdef TLMEM_BOUNDS_CHECK_EN
    assign oob = (a_off >= (32'(MEM_WORDS) << 3));
`else
    assign oob = 1'b0;
`endif

    // Response path skips DELAY entirely when no idle cycles are wanted.
    assign post_state = (RESP_DELAY == 0) ? RESP : DELAY;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        size_d  = size_q;
        idx_d   = idx_q;
        left_d  = left_q;
        dly_d   = dly_q;
        get_d   = get_q;
        den_d   = den_q;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        wr_mask = a_mask;
        wr_data = a_data;

        unique case (state_q)
            IDLE: begin
                if (a_hs) begin
                    src_d  = a_source;
                    size_d = a_size;
                    idx_d  = a_idx;
                    get_d  = op_get;
                    den_d  = oob || !(op_put || op_get);
                    dly_d  = DLY_INIT;
                    left_d = 13'd1;
                    if (op_get) begin
                        left_d  = a_beats;
                        state_d = post_state;
                    end else if (op_put) begin
                        wr_en  = !oob;
                        wr_idx = a_idx;
                        if (a_beats == 13'd1) begin
                            state_d = post_state;
                        end else begin
                            left_d  = a_beats - 13'd1;
                            idx_d   = a_idx + 1'b1;
                            state_d = WDATA;
                        end
                    end else begin
                        state_d = post_state;
                    end
                end
            end
            WDATA: begin
                if (a_hs) begin
                    wr_en  = !den_q;
                    wr_idx = idx_q;
                    idx_d  = idx_q + 1'b1;
                    left_d = left_q - 13'd1;
                    if (left_q == 13'd1) begin
                        // Last data beat: reuse counter for the single ack.
                        left_d  = 13'd1;
                        dly_d   = DLY_INIT;
                        state_d = post_state;
                    end
                end
            end
            DELAY: begin
                if (dly_q == 4'd0) state_d = RESP;
                else               dly_d   = dly_q - 4'd1;
            end
            RESP: begin
                if (d_hs) begin
                    idx_d  = idx_q + 1'b1;
                    left_d = left_q - 13'd1;
                    if (left_q == 13'd1) state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            src_q   <= 1'b0;
            size_q  <= 4'd0;
            idx_q   <= '0;
            left_q  <= 13'd0;
            dly_q   <= 4'd0;
            get_q   <= 1'b0;
            den_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            size_q  <= size_d;
            idx_q   <= idx_d;
            left_q  <= left_d;
            dly_q   <= dly_d;
            get_q   <= get_d;
            den_q   <= den_d;
        end
    end

    // Memory is never reset; a beat presented during reset is dropped.
    always_ff @(posedge clock) begin
        if (wr_en && resetn) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign d_opcode = (d_valid && get_q) ? 3'd1 : 3'd0;
    assign d_size   = d_valid ? size_q : 4'd0;
    assign d_source = d_valid && src_q;
    assign d_denied = d_valid && den_q;
    assign d_data   = (d_valid && get_q && !den_q) ? mem[idx_q] : 64'd0;

endmodule
